bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_pkg.sv | 17 +
 rtl/bin2bcd_seq_bcd_nibble_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 tb/tb_bin2bcd_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// state encodings, default sizing and the iteration-counter width.
package bin2bcd_seq_pkg;

    localparam int unsigned BIN_W_DEF  = 16;
    localparam int unsigned DIGITS_DEF = 5;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ADJUST = 2'b01;
    localparam logic [1:0] ST_SHIFT  = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    function automatic int unsigned cnt_width(input int unsigned bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_nibble_adj.sv
// Double-dabble correction cell: a nibble of 5 or more gets +3 (wraps within 4 bits).
module bcd_nibble_adj (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (nib_in >= 4'd5) begin
            nib_out = nib_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/done handshake
// and a leading-zero blanking mask for the seven-segment drivers.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = cnt_width(BIN_W);

    logic [1:0]        state;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  scratch_adj;
    logic [BCD_W-1:0]  scratch_sh;
    logic [BIN_W-1:0]  shreg;
    logic [BIN_W-1:0]  shreg_sh;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DIGITS-1:0] lz_nxt;
    logic              nz_seen;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_in  (scratch[4*g +: 4]),
            .nib_out (scratch_adj[4*g +: 4])
        );
    end

    always_comb begin
        {scratch_sh, shreg_sh} = {scratch, shreg} << 1;
        cnt_nxt                = cnt + CNT_W'(1);
    end

    // Mask is derived from the post-shift scratch so it lands with bcd_out.
    always_comb begin
        lz_nxt  = '0;
        nz_seen = 1'b0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (scratch_sh[4*i +: 4] != 4'd0) begin
                nz_seen = 1'b1;
            end
            lz_nxt[i] = ~nz_seen;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
            valid   <= 1'b0;
            bcd_out <= '0;
            lz_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        valid   <= 1'b0;
                        state   <= ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    scratch <= scratch_adj;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    scratch <= scratch_sh;
                    shreg   <= shreg_sh;
                    cnt     <= cnt_nxt;
                    if (cnt_nxt == CNT_W'(BIN_W)) begin
                        bcd_out <= scratch_sh;
                        lz_mask <= lz_nxt;
                        valid   <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        state   <= ST_ADJUST;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_ADJUST) || (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a divide/modulo decimal reference.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic [15:0] bin_in     = '0;
    logic        busy;
    logic        done;
    logic        valid;
    logic [19:0] bcd_out;
    logic [4:0]  lz_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .bcd_out    (bcd_out),
        .lz_mask    (lz_mask)
    );

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_lz(input int unsigned v);
        logic [4:0] m;
        int unsigned p;
        m = '0;
        p = 10;
        // digit i is a leading zero exactly when v < 10^i
        for (int i = 1; i < 5; i++) begin
            m[i] = (v < p);
            p = p * 10;
        end
        return m;
    endfunction

    // Waits for idle, issues one start, then waits (bounded) for done.
    task automatic convert(input logic [15:0] v, output int lat,
                           output int busy_cnt, output logic valid_after);
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk_100MHz);
        #1;
        start       = 1'b0;
        bin_in      = 16'($urandom);
        valid_after = valid;
        busy_cnt    = (busy === 1'b1) ? 1 : 0;
        lat         = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk_100MHz);
            #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_100MHz);
        #1;
        checks++;
        if ({busy, done, valid, bcd_out, lz_mask} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b bcd=%h lz=%b, want all zero",
                     busy, done, valid, bcd_out, lz_mask);
        end
        @(negedge clk_100MHz);
        reset_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat, bc;
        logic va;
        convert(16'd0, lat, bc, va);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles, want 32", lat);
        end
        checks++;
        if (bcd_out !== 20'h00000 || lz_mask !== 5'b11110 || valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_result: got bcd=%h lz=%b valid=%b, want 00000 11110 1",
                     bcd_out, lz_mask, valid);
        end
    endtask

    task automatic test_max();
        int lat, bc;
        logic va;
        convert(16'd65535, lat, bc, va);
        checks++;
        if (bcd_out !== 20'h65535 || lz_mask !== 5'b00000) begin
            errors++;
            $display("FAIL max_result: got bcd=%h lz=%b, want 65535 00000", bcd_out, lz_mask);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic va;
        convert(16'd1234, lat, bc, va);
        checks++;
        if (bcd_out !== 20'h01234 || lz_mask !== 5'b10000 || valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got bcd=%h lz=%b valid=%b, want 01234 10000 1",
                     bcd_out, lz_mask, valid);
        end
        convert(16'd9, lat, bc, va);
        checks++;
        if (va !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_drop: got valid=%b after start, want 0", va);
        end
        checks++;
        if (bcd_out !== 20'h00009 || lz_mask !== 5'b11110 || valid !== 1'b1 || lat !== 32) begin
            errors++;
            $display("FAIL b2b_second: got bcd=%h lz=%b valid=%b lat=%0d, want 00009 11110 1 32",
                     bcd_out, lz_mask, valid, lat);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        start  = 1'b1;
        bin_in = 16'd500;
        @(posedge clk_100MHz);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk_100MHz);
        #1;
        start  = 1'b1;
        bin_in = 16'd7;
        @(posedge clk_100MHz);
        #1;
        start = 1'b0;
        lat   = 10;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk_100MHz);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 32 || bcd_out !== 20'h00500) begin
            errors++;
            $display("FAIL ignore_busy: got bcd=%h lat=%0d, want 00500 32", bcd_out, lat);
        end
        start  = 1'b1;
        bin_in = 16'd7;
        @(posedge clk_100MHz);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b1 || bcd_out !== 20'h00500) begin
            errors++;
            $display("FAIL ignore_done: got busy=%b valid=%b bcd=%h, want 0 1 00500",
                     busy, valid, bcd_out);
        end
        @(posedge clk_100MHz);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_after_done: got busy=%b valid=%b, want 1 0", busy, valid);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk_100MHz);
            #1;
            lat++;
        end
        checks++;
        if (bcd_out !== 20'h00007 || lat !== 32) begin
            errors++;
            $display("FAIL accept_result: got bcd=%h lat=%0d, want 00007 32", bcd_out, lat);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        logic va;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        start  = 1'b1;
        bin_in = 16'd4321;
        @(posedge clk_100MHz);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk_100MHz);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, valid, bcd_out, lz_mask} !== 28'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b bcd=%h lz=%b, want all zero",
                     busy, done, valid, bcd_out, lz_mask);
        end
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        convert(16'd42, lat, bc, va);
        checks++;
        if (bcd_out !== 20'h00042 || lz_mask !== 5'b11100 || lat !== 32) begin
            errors++;
            $display("FAIL after_reset: got bcd=%h lz=%b lat=%0d, want 00042 11100 32",
                     bcd_out, lz_mask, lat);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic va;
        logic [15:0] v;
        for (int n = 0; n < 1000; n++) begin
            v = 16'($urandom);
            convert(v, lat, bc, va);
            checks++;
            if (bcd_out !== ref_bcd(v) || lz_mask !== ref_lz(v)) begin
                errors++;
                $display("FAIL rand_result: in=%0d got bcd=%h lz=%b, want %h %b",
                         v, bcd_out, lz_mask, ref_bcd(v), ref_lz(v));
            end
            checks++;
            if (lat !== 32 || bc !== 32) begin
                errors++;
                $display("FAIL rand_timing: in=%0d got lat=%0d busy=%0d, want 32 32", v, lat, bc);
            end
            @(posedge clk_100MHz);
            #1;
            checks++;
            if (done !== 1'b0 || valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_done_width: got done=%b valid=%b, want 0 1", done, valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_ignored_start();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
